// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - T-state constants shared by the sequencer and the control-word decoder
package cpu_pkg;

  localparam int NUM_T_STATES = 6;

  localparam logic [2:0] T1_IDX = 3'd0;
  localparam logic [2:0] T2_IDX = 3'd1;
  localparam logic [2:0] T3_IDX = 3'd2;
  localparam logic [2:0] T4_IDX = 3'd3;
  localparam logic [2:0] T5_IDX = 3'd4;
  localparam logic [2:0] T6_IDX = 3'd5;

  localparam logic [2:0] FETCH_LAST_IDX = T3_IDX;

  // Lowest set bit wins, so a corrupted vector still yields a stable index.
  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = T1_IDX;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/t_state_counter_if.sv
// rtl/t_state_counter_if.sv - control and status bundle of the T-state sequencer (step only with T_STATE_STEP_EN)
interface t_state_counter_if #(
  parameter int NUM_STATES = 6,
  parameter int CNT_W      = 8
);
  logic                  hlt;
  logic                  restart;
`ifdef T_STATE_STEP_EN
  logic                  step;
`endif
  logic [NUM_STATES-1:0] t_state;
  logic [2:0]            t_index;
  logic                  fetch;
  logic                  cycle_done;
  logic [CNT_W-1:0]      instr_count;

  modport master (
    output hlt, restart,
`ifdef T_STATE_STEP_EN
    output step,
`endif
    input  t_state, t_index, fetch, cycle_done, instr_count
  );

  modport slave (
    input  hlt, restart,
`ifdef T_STATE_STEP_EN
    input  step,
`endif
    output t_state, t_index, fetch, cycle_done, instr_count
  );
endinterface

// File: rtl/step_edge.sv
// rtl/step_edge.sv - synchronous rising-edge detector whose history resets high
module step_edge (
  input  logic clk,
  input  logic clr_n,
  input  logic hold,
  input  logic d,
  output logic rise
);
  logic prev_q, prev_d;

  always_comb begin
    prev_d = prev_q;
    if (!hold) prev_d = d;
  end

  // History resets to 1 so a level held through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!clr_n) prev_q <= 1'b1;
    else        prev_q <= prev_d;
  end

  assign rise = d & ~prev_q;
endmodule

// File: rtl/t_state_counter.sv
// rtl/t_state_counter.sv - one-hot T1..Tn ring with halt, restart and completion count; T_STATE_STEP_EN adds single-step
module t_state_counter
  import cpu_pkg::*;
#(
  parameter int NUM_STATES = NUM_T_STATES,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  t_state_counter_if.slave  bus
);
  logic [NUM_STATES-1:0] t_state_q, t_state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  done_q, done_d;
  logic                  adv_en;
  logic                  legal;
  logic [2:0]            idx;

`ifdef T_STATE_STEP_EN
  step_edge u_step_edge (
    .clk   (clk),
    .clr_n (clr_n),
    .hold  (bus.hlt),
    .d     (bus.step),
    .rise  (adv_en)
  );
`else
  assign adv_en = 1'b1;
`endif

  assign legal = $onehot(t_state_q);

  always_comb begin
    t_state_d = t_state_q;
    count_d   = count_q;
    done_d    = 1'b0;
    if (!bus.hlt) begin
      if (!legal) begin
        t_state_d = NUM_STATES'(1);
      end else if (adv_en) begin
        if (bus.restart || t_state_q[NUM_STATES-1]) begin
          t_state_d = NUM_STATES'(1);
          done_d    = 1'b1;
          count_d   = count_q + CNT_W'(1);
        end else begin
          t_state_d = t_state_q << 1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      t_state_q <= NUM_STATES'(1);
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      t_state_q <= t_state_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

  assign idx             = onehot_idx(8'(t_state_q));
  assign bus.t_state     = t_state_q;
  assign bus.t_index     = idx;
  assign bus.fetch       = (idx <= FETCH_LAST_IDX);
  assign bus.cycle_done  = done_q;
  assign bus.instr_count = count_q;
endmodule

// File: tb/tb_t_state_counter.sv
// tb/tb_t_state_counter.sv - directed self-checking bench for t_state_counter
module tb_t_state_counter;
  logic clk = 1'b0;
  logic clr_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  t_state_counter_if #(.NUM_STATES(6), .CNT_W(8)) bus_a ();
  t_state_counter_if #(.NUM_STATES(6), .CNT_W(2)) bus_b ();

  t_state_counter #(.NUM_STATES(6), .CNT_W(8)) dut_a (.clk(clk), .clr_n(clr_n), .bus(bus_a));
  t_state_counter #(.NUM_STATES(6), .CNT_W(2)) dut_b (.clk(clk), .clr_n(clr_n), .bus(bus_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus_a.t_state !== 6'd1) begin bad++; $display("FAIL reset_t_state got=%0d exp=1", bus_a.t_state); end
    total++; if (bus_a.t_index !== 3'd0) begin bad++; $display("FAIL reset_t_index got=%0d exp=0", bus_a.t_index); end
    total++; if (bus_a.fetch !== 1'b1) begin bad++; $display("FAIL reset_fetch got=%0b exp=1", bus_a.fetch); end
    total++; if (bus_a.cycle_done !== 1'b0) begin bad++; $display("FAIL reset_cycle_done got=%0b exp=0", bus_a.cycle_done); end
    total++; if (bus_a.instr_count !== 8'd0) begin bad++; $display("FAIL reset_instr_count got=%0d exp=0", bus_a.instr_count); end
  endtask

  task automatic test_free_run();
    logic [5:0] exp_ts;
    logic [2:0] exp_idx;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp_idx = 3'(k % 6);
      exp_ts  = 6'd1 << exp_idx;
      total++; if (bus_a.t_state !== exp_ts) begin bad++; $display("FAIL free_t_state cyc=%0d got=%0d exp=%0d", k, bus_a.t_state, exp_ts); end
      total++; if (bus_a.t_index !== exp_idx) begin bad++; $display("FAIL free_t_index cyc=%0d got=%0d exp=%0d", k, bus_a.t_index, exp_idx); end
      total++; if (bus_a.fetch !== (exp_idx < 3)) begin bad++; $display("FAIL free_fetch cyc=%0d got=%0b exp=%0b", k, bus_a.fetch, exp_idx < 3); end
      total++; if (bus_a.cycle_done !== (k % 6 == 0)) begin bad++; $display("FAIL free_cycle_done cyc=%0d got=%0b exp=%0b", k, bus_a.cycle_done, k % 6 == 0); end
    end
    total++; if (bus_a.instr_count !== 8'd2) begin bad++; $display("FAIL free_instr_count got=%0d exp=2", bus_a.instr_count); end
  endtask

  task automatic test_restart();
    do_reset();
    tick(); tick();
    total++; if (bus_a.t_state !== 6'd4) begin bad++; $display("FAIL restart_pre_t3 got=%0d exp=4", bus_a.t_state); end
    bus_a.restart = 1'b1;
    tick();
    bus_a.restart = 1'b0;
    total++; if (bus_a.t_state !== 6'd1) begin bad++; $display("FAIL restart_t1 got=%0d exp=1", bus_a.t_state); end
    total++; if (bus_a.cycle_done !== 1'b1) begin bad++; $display("FAIL restart_pulse got=%0b exp=1", bus_a.cycle_done); end
    total++; if (bus_a.instr_count !== 8'd1) begin bad++; $display("FAIL restart_count got=%0d exp=1", bus_a.instr_count); end
    tick();
    total++; if (bus_a.t_state !== 6'd2) begin bad++; $display("FAIL restart_next_t2 got=%0d exp=2", bus_a.t_state); end
    total++; if (bus_a.cycle_done !== 1'b0) begin bad++; $display("FAIL restart_pulse_end got=%0b exp=0", bus_a.cycle_done); end
  endtask

  task automatic test_restart_in_t1();
    do_reset();
    bus_a.restart = 1'b1;
    tick();
    bus_a.restart = 1'b0;
    total++; if (bus_a.t_state !== 6'd1) begin bad++; $display("FAIL t1_restart_state got=%0d exp=1", bus_a.t_state); end
    total++; if (bus_a.cycle_done !== 1'b1) begin bad++; $display("FAIL t1_restart_pulse got=%0b exp=1", bus_a.cycle_done); end
    total++; if (bus_a.instr_count !== 8'd1) begin bad++; $display("FAIL t1_restart_count got=%0d exp=1", bus_a.instr_count); end
  endtask

  task automatic test_halt();
    do_reset();
    tick(); tick(); tick();
    total++; if (bus_a.t_state !== 6'd8) begin bad++; $display("FAIL halt_pre_t4 got=%0d exp=8", bus_a.t_state); end
    bus_a.hlt = 1'b1;
    bus_a.restart = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (bus_a.t_state !== 6'd8) begin bad++; $display("FAIL halt_hold_state cyc=%0d got=%0d exp=8", k, bus_a.t_state); end
      total++; if (bus_a.instr_count !== 8'd0) begin bad++; $display("FAIL halt_hold_count cyc=%0d got=%0d exp=0", k, bus_a.instr_count); end
      total++; if (bus_a.cycle_done !== 1'b0) begin bad++; $display("FAIL halt_hold_pulse cyc=%0d got=%0b exp=0", k, bus_a.cycle_done); end
    end
    bus_a.hlt = 1'b0;
    tick();
    bus_a.restart = 1'b0;
    total++; if (bus_a.t_state !== 6'd1) begin bad++; $display("FAIL halt_release_state got=%0d exp=1", bus_a.t_state); end
    total++; if (bus_a.cycle_done !== 1'b1) begin bad++; $display("FAIL halt_release_pulse got=%0b exp=1", bus_a.cycle_done); end
    total++; if (bus_a.instr_count !== 8'd1) begin bad++; $display("FAIL halt_release_count got=%0d exp=1", bus_a.instr_count); end
  endtask

  task automatic test_reset_with_restart();
    do_reset();
    bus_a.restart = 1'b1;
    tick();
    bus_a.restart = 1'b0;
    tick(); tick(); tick(); tick();
    total++; if (bus_a.t_state !== 6'd16) begin bad++; $display("FAIL clr_pre_t5 got=%0d exp=16", bus_a.t_state); end
    clr_n = 1'b0;
    bus_a.restart = 1'b1;
    tick();
    clr_n = 1'b1;
    bus_a.restart = 1'b0;
    total++; if (bus_a.t_state !== 6'd1) begin bad++; $display("FAIL clr_restart_state got=%0d exp=1", bus_a.t_state); end
    total++; if (bus_a.cycle_done !== 1'b0) begin bad++; $display("FAIL clr_restart_pulse got=%0b exp=0", bus_a.cycle_done); end
    total++; if (bus_a.instr_count !== 8'd0) begin bad++; $display("FAIL clr_restart_count got=%0d exp=0", bus_a.instr_count); end
  endtask

  task automatic test_count_wrap();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int n = 0; n < 5; n++) begin
      for (int k = 0; k < 6; k++) tick();
      total++; if (bus_b.instr_count !== exp_cnt[n]) begin bad++; $display("FAIL wrap_count instr=%0d got=%0d exp=%0d", n + 1, bus_b.instr_count, exp_cnt[n]); end
      total++; if (bus_b.cycle_done !== 1'b1) begin bad++; $display("FAIL wrap_pulse instr=%0d got=%0b exp=1", n + 1, bus_b.cycle_done); end
    end
  endtask

`ifdef T_STATE_STEP_EN
  task automatic test_step();
    logic [5:0] exp_ts [3];
    exp_ts = '{6'd2, 6'd4, 6'd8};
    bus_a.step = 1'b1;
    do_reset();
    tick(); tick();
    total++; if (bus_a.t_state !== 6'd1) begin bad++; $display("FAIL step_held_state got=%0d exp=1", bus_a.t_state); end
    for (int n = 0; n < 3; n++) begin
      bus_a.step = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        total++; if (bus_a.t_state !== (n == 0 ? 6'd1 : exp_ts[n-1])) begin bad++; $display("FAIL step_idle_state edge=%0d got=%0d", n, bus_a.t_state); end
      end
      bus_a.step = 1'b1;
      tick();
      total++; if (bus_a.t_state !== exp_ts[n]) begin bad++; $display("FAIL step_edge_state edge=%0d got=%0d exp=%0d", n, bus_a.t_state, exp_ts[n]); end
    end
  endtask
`endif

  initial begin
    clr_n         = 1'b0;
    bus_a.hlt     = 1'b0;
    bus_a.restart = 1'b0;
    bus_b.hlt     = 1'b0;
    bus_b.restart = 1'b0;
`ifdef T_STATE_STEP_EN
    bus_a.step    = 1'b0;
    bus_b.step    = 1'b0;
`endif
    #2;
    test_reset();
`ifdef T_STATE_STEP_EN
    test_step();
`else
    test_free_run();
    test_restart();
    test_restart_in_t1();
    test_halt();
    test_reset_with_restart();
    test_count_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
